// File: rtl/seg_bcd_driver_pkg.sv
// seg_bcd_driver_pkg: segment patterns, FSM/channel enums and the double-dabble adjust step
package seg_bcd_driver_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
  typedef enum logic {CH_PC, CH_REG} chan_t;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // add 3 to every BCD digit that is 5 or more, ahead of the left shift
  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++)
      r[i*4+:4] = b[i*4+:4] >= 4'd5 ? b[i*4+:4] + 4'd3 : b[i*4+:4];
    return r;
  endfunction
endpackage

// File: rtl/seg_bcd_driver_seg7_encode.sv
// seg7_encode: BCD digit to active-low 7-segment pattern (non-decimal codes blank)
module seg7_encode
  import seg_bcd_driver_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);
  always_comb begin
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg_bcd_driver.sv
// seg_bcd_driver: shared double-dabble converter feeding PC and register 7-seg pairs plus a final flag.
// Build option LEADING_ZERO_BLANK_EN blanks a zero tens digit on both channels.
module seg_bcd_driver #(
  parameter int WIDTH  = 8,
  parameter int MAXVAL = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_register,
  input  logic        i_final,
  input  logic        i_hold,
  output logic [6:0]  o_display1,
  output logic [6:0]  o_display2,
  output logic [6:0]  o_display3,
  output logic [6:0]  o_display4,
  output logic [6:0]  o_display5,
  output logic        o_valid
);
  import seg_bcd_driver_pkg::*;
  state_t           r_state, w_next;
  chan_t            r_chan;
  logic [WIDTH-1:0] r_snap, r_bin, w_sel;
  logic [11:0]      r_bcd, w_adj;
  logic [4:0]       r_cnt;
  logic             r_skip, r_valid;
  logic [6:0]       r_d1, r_d2, r_d3, r_d4, r_d5;
  logic [6:0]       w_enc [4];
  logic [6:0]       w_pc_u, w_pc_t, w_rg_u, w_rg_t;
  logic             w_load, w_shift, w_commit, w_over, w_tz;
  logic             w_unused;
  assign w_unused = &{1'b0, i_pc[31:WIDTH], i_register[31:WIDTH], w_adj[11]};
  assign w_adj    = dd_adjust(r_bcd);
  assign w_sel    = r_chan == CH_PC ? i_pc[WIDTH-1:0] : i_register[WIDTH-1:0];
  assign w_over   = 32'(r_snap) > 32'(MAXVAL);
`ifdef LEADING_ZERO_BLANK_EN
  assign w_tz = r_bcd[7:4] == 4'd0;
`else
  assign w_tz = 1'b0;
`endif
  seg7_encode u_pc_u (.i_digit(r_bcd[3:0]), .o_seg(w_enc[0]));
  seg7_encode u_pc_t (.i_digit(r_bcd[7:4]), .o_seg(w_enc[1]));
  seg7_encode u_rg_u (.i_digit(r_bcd[3:0]), .o_seg(w_enc[2]));
  seg7_encode u_rg_t (.i_digit(r_bcd[7:4]), .o_seg(w_enc[3]));
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state == IDLE  ? (i_hold ? IDLE : LOAD) :
             r_state == LOAD  ? SHIFT :
             r_state == SHIFT ? (r_cnt == 5'd1 ? LATCH : SHIFT) : IDLE;
  end
  // a hold seen anywhere in the conversion lets it finish but suppresses the latch
  always_comb begin
    w_load   = r_state == LOAD;
    w_shift  = r_state == SHIFT;
    w_commit = r_state == LATCH && !r_skip && !i_hold;
    w_pc_u   = w_over ? SEG_DASH : w_enc[0];
    w_pc_t   = w_over ? SEG_DASH : w_tz ? SEG_BLANK : w_enc[1];
    w_rg_u   = w_over ? SEG_DASH : w_enc[2];
    w_rg_t   = w_over ? SEG_DASH : w_tz ? SEG_BLANK : w_enc[3];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chan  <= CH_PC;
      r_snap  <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_skip  <= 1'b0;
      r_valid <= 1'b0;
      r_d1    <= SEG_BLANK;
      r_d2    <= SEG_BLANK;
      r_d3    <= SEG_BLANK;
      r_d4    <= SEG_BLANK;
      r_d5    <= SEG_BLANK;
    end else begin
      r_valid <= w_commit;
      r_skip  <= r_state == IDLE ? 1'b0 : r_skip | i_hold;
      if (!i_hold) r_d5 <= i_final ? SEG_F : SEG_BLANK;
      if (w_load) begin
        r_snap <= w_sel;
        r_bin  <= w_sel;
        r_bcd  <= '0;
        r_cnt  <= 5'(WIDTH);
      end
      if (w_shift) begin
        {r_bcd, r_bin} <= {w_adj[10:0], r_bin, 1'b0};
        r_cnt          <= r_cnt - 5'd1;
      end
      if (w_commit) begin
        if (r_chan == CH_PC) begin
          r_d1 <= w_pc_u;
          r_d2 <= w_pc_t;
        end else begin
          r_d3 <= w_rg_u;
          r_d4 <= w_rg_t;
        end
        r_chan <= r_chan == CH_PC ? CH_REG : CH_PC;
      end
    end
  end
  assign o_display1 = r_d1;
  assign o_display2 = r_d2;
  assign o_display3 = r_d3;
  assign o_display4 = r_d4;
  assign o_display5 = r_d5;
  assign o_valid    = r_valid;
endmodule
